// File: rtl/clk_div_gen_if.sv
// -----------------------------------------------------------------------------
// clk_div_gen_if
// Signal bundle between the power-of-two clock divider and its user.
//   enable    : run request (level)
//   clk_out   : divided clocks, bit k divides clk_32f by 2^(FIRST_DIV_LOG2+k)
//   rise_stb  : one-cycle strobe per output on its rising edge
//   locked    : outputs running and stable
//   running   : divider is in RUN or STOPPING
//   clk_exp   : expected clocks for the built-in checker   (CLK_CHECK_EN only)
//   mismatch  : sticky per-output mismatch flags           (CLK_CHECK_EN only)
//   err_cnt   : saturating mismatch-cycle count            (CLK_CHECK_EN only)
// Modports: master = user side, slave = divider side.
// Optional checker signals are present only when CLK_CHECK_EN is defined.
// -----------------------------------------------------------------------------
interface clk_div_gen_if #(
    parameter int N_OUT = 3
);
    logic             enable;
    logic [N_OUT-1:0] clk_out;
    logic [N_OUT-1:0] rise_stb;
    logic             locked;
    logic             running;
`ifdef CLK_CHECK_EN
    logic [N_OUT-1:0] clk_exp;
    logic [N_OUT-1:0] mismatch;
    logic [7:0]       err_cnt;

    modport master (
        output enable, clk_exp,
        input  clk_out, rise_stb, locked, running, mismatch, err_cnt
    );
    modport slave (
        input  enable, clk_exp,
        output clk_out, rise_stb, locked, running, mismatch, err_cnt
    );
`else
    modport master (
        output enable,
        input  clk_out, rise_stb, locked, running
    );
    modport slave (
        input  enable,
        output clk_out, rise_stb, locked, running
    );
`endif
endinterface

// File: rtl/clk_div_gen.sv
// -----------------------------------------------------------------------------
// clk_div_gen
// Power-of-two clock divider producing N_OUT phase-aligned divided clocks from
// clk_32f, with run/stop control (stop only at the slowest-clock boundary),
// per-output rising-edge strobes and a lock indication.
//
// Ports:
//   clk_32f : reference clock, all logic on its rising edge
//   reset   : asynchronous, active-low reset
//   bus     : clk_div_gen_if.slave (enable, clk_out, rise_stb, locked, running
//             and, with CLK_CHECK_EN, clk_exp / mismatch / err_cnt)
//
// Optional feature macro: CLK_CHECK_EN -- when defined, a checker compares
// clk_out against bus.clk_exp while locked and keeps sticky mismatch flags and
// a saturating error count. Undefined: checker logic and ports are absent.
// -----------------------------------------------------------------------------
module clk_div_gen #(
    parameter int N_OUT          = 3,
    parameter int FIRST_DIV_LOG2 = 3,
    parameter int LOCK_PERIODS   = 1
) (
    input  logic          clk_32f,
    input  logic          reset,
    clk_div_gen_if.slave  bus
);
    localparam int          W        = FIRST_DIV_LOG2 + N_OUT - 1;
    localparam logic [3:0]  LOCK_TGT = 4'(LOCK_PERIODS);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    state_t         state_reg;
    logic [W-1:0]   cnt_reg;
    logic [3:0]     lock_cnt_reg;
    logic           locked_reg;
    logic           cnt_max;
    logic           running;

    assign cnt_max = &cnt_reg;
    assign running = (state_reg != IDLE);

    // Main FSM. The counter holds at 0 in IDLE so that every restart begins
    // with all outputs low and phase-aligned; STOPPING only exits to IDLE on
    // the wrap, so no output ever sees a truncated phase.
    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            lock_cnt_reg <= '0;
            locked_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    cnt_reg      <= '0;
                    lock_cnt_reg <= '0;
                    locked_reg   <= 1'b0;
                    if (bus.enable) begin
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    cnt_reg <= cnt_reg + W'(1);
                    if (!bus.enable) begin
                        state_reg    <= STOPPING;
                        lock_cnt_reg <= '0;
                        locked_reg   <= 1'b0;
                    end else if (cnt_max && (lock_cnt_reg != LOCK_TGT)) begin
                        lock_cnt_reg <= lock_cnt_reg + 4'd1;
                        locked_reg   <= ((lock_cnt_reg + 4'd1) == LOCK_TGT);
                    end
                end
                STOPPING: begin
                    // Counting continues uninterrupted; resuming restarts the
                    // lock count from zero (it was cleared on entry here).
                    cnt_reg <= cnt_reg + W'(1);
                    if (bus.enable) begin
                        state_reg <= RUN;
                    end else if (cnt_max) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg    <= IDLE;
                    cnt_reg      <= '0;
                    lock_cnt_reg <= '0;
                    locked_reg   <= 1'b0;
                end
            endcase
        end
    end

    logic [N_OUT-1:0] clk_out_w;
    logic [N_OUT-1:0] rise_stb_w;

    // Output k is counter bit B directly; its strobe fires when the low B+1
    // counter bits read 1 followed by B zeros, i.e. the cycle bit B just rose.
    generate
        for (genvar gi = 0; gi < N_OUT; gi++) begin : g_out
            localparam int         B   = FIRST_DIV_LOG2 - 1 + gi;
            localparam logic [B:0] ONE = (B+1)'(1);
            localparam logic [B:0] PAT = ONE << B;
            assign clk_out_w[gi]  = cnt_reg[B];
            assign rise_stb_w[gi] = running && (cnt_reg[B:0] == PAT);
        end
    endgenerate

    assign bus.clk_out  = clk_out_w;
    assign bus.rise_stb = rise_stb_w;
    assign bus.locked   = locked_reg;
    assign bus.running  = running;

`ifdef CLK_CHECK_EN
    logic [N_OUT-1:0] mismatch_reg;
    logic [7:0]       err_cnt_reg;
    logic [N_OUT-1:0] diff;

    assign diff = clk_out_w ^ bus.clk_exp;

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            mismatch_reg <= '0;
            err_cnt_reg  <= '0;
        end else if ((state_reg == IDLE) && bus.enable) begin
            mismatch_reg <= '0;
            err_cnt_reg  <= '0;
        end else if (locked_reg && (|diff)) begin
            mismatch_reg <= mismatch_reg | diff;
            if (err_cnt_reg != 8'hFF) begin
                err_cnt_reg <= err_cnt_reg + 8'd1;
            end
        end
    end

    assign bus.mismatch = mismatch_reg;
    assign bus.err_cnt  = err_cnt_reg;
`endif

endmodule

// File: tb/tb_clk_div_gen.sv
module tb_clk_div_gen;
    localparam int N_OUT = 3;
    localparam int FDL   = 3;
    localparam int LP    = 1;
    localparam int W     = FDL + N_OUT - 1;
    localparam int MAXC  = (1 << W) - 1;
    localparam int EW    = 2 * N_OUT + 2;

    logic clk_32f = 1'b0;
    logic reset   = 1'b0;
    always #5 clk_32f = ~clk_32f;

    clk_div_gen_if #(.N_OUT(N_OUT)) bus_if ();

    clk_div_gen #(
        .N_OUT(N_OUT), .FIRST_DIV_LOG2(FDL), .LOCK_PERIODS(LP)
    ) dut (
        .clk_32f(clk_32f),
        .reset  (reset),
        .bus    (bus_if)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: state 0=IDLE 1=RUN 2=STOPPING
    int m_st = 0, m_cnt = 0, m_lk = 0;
    bit m_locked = 1'b0;
    logic [EW-1:0] sb[$];

    function automatic logic [EW-1:0] model_out(int cnt, int st, bit lk);
        logic [N_OUT-1:0] co, rs;
        int b;
        for (int k = 0; k < N_OUT; k++) begin
            b = FDL - 1 + k;
            co[k] = (((cnt >> b) & 1) == 1);
            rs[k] = (st != 0) && ((cnt % (1 << (b + 1))) == (1 << b));
        end
        return {co, rs, lk, (st != 0)};
    endfunction

    always @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            m_st = 0; m_cnt = 0; m_lk = 0; m_locked = 1'b0;
        end else begin
            case (m_st)
                0: if (bus_if.enable) m_st = 1;
                1: begin
                    if (!bus_if.enable) begin
                        m_st = 2; m_lk = 0;
                    end else if (m_cnt == MAXC && m_lk < LP) begin
                        m_lk++;
                    end
                    m_cnt = (m_cnt + 1) % (MAXC + 1);
                end
                default: begin
                    if (bus_if.enable) m_st = 1;
                    else if (m_cnt == MAXC) m_st = 0;
                    m_cnt = (m_cnt + 1) % (MAXC + 1);
                end
            endcase
            m_locked = (m_st == 1) && (m_lk >= LP);
            sb.push_back(model_out(m_cnt, m_st, m_locked));
        end
    end

    logic [EW-1:0] obs;
    assign obs = {bus_if.clk_out, bus_if.rise_stb, bus_if.locked, bus_if.running};

`ifdef CLK_CHECK_EN
    logic [N_OUT-1:0] inv_mask = '0;
    always @(negedge clk_32f) begin
        logic [EW-1:0] e;
        e = model_out(m_cnt, m_st, m_locked);
        bus_if.clk_exp <= e[EW-1 -: N_OUT] ^ inv_mask;
    end
`endif

    task automatic test_reset();
        logic [EW-1:0] exp;
        reset = 1'b0;
        bus_if.enable = 1'b0;
        repeat (2) @(negedge clk_32f);
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL reset_state: got %b want %b", obs, {EW{1'b0}});
        end
`ifdef CLK_CHECK_EN
        checks++;
        if (bus_if.mismatch !== '0 || bus_if.err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_checker: got mismatch=%b err=%0d want 0/0",
                     bus_if.mismatch, bus_if.err_cnt);
        end
`endif
        reset = 1'b1;
        sb.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_32f);
            checks++;
            if (sb.size() == 0) begin
                errors++; $display("FAIL idle_sb: scoreboard empty at %0d", i);
            end else begin
                exp = sb.pop_front();
                if (obs !== exp) begin
                    errors++; $display("FAIL idle cyc%0d: got %b want %b", i, obs, exp);
                end
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_run();
        logic [EW-1:0] exp;
        int lock_at = -1, r0 = 0, r2 = 0;
        @(negedge clk_32f);
        bus_if.enable = 1'b1;
        sb.delete();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_32f);
            checks++;
            if (sb.size() == 0) begin
                errors++; $display("FAIL run_sb: scoreboard empty at %0d", i);
            end else begin
                exp = sb.pop_front();
                if (obs !== exp) begin
                    errors++; $display("FAIL run cyc%0d: got %b want %b", i, obs, exp);
                end
            end
            if (bus_if.locked && lock_at < 0) lock_at = i;
            if (i < 96 && bus_if.rise_stb[0]) r0++;
            if (i < 96 && bus_if.rise_stb[2]) r2++;
        end
        checks++;
        if (lock_at !== 32) begin
            errors++; $display("FAIL lock_latency: got %0d want 32", lock_at);
        end
        checks++;
        if (r0 !== 12 || r2 !== 3) begin
            errors++; $display("FAIL rise_counts: got %0d/%0d want 12/3", r0, r2);
        end
        $display("test_run done: lock_at=%0d rise0=%0d rise2=%0d", lock_at, r0, r2);
    endtask

    task automatic test_stop();
        logic [EW-1:0] exp;
        int t, idle_at = -1;
        for (t = 0; t < 100 && m_cnt != 5; t++) @(negedge clk_32f);
        checks++;
        if (m_cnt != 5) begin
            errors++; $display("FAIL stop_wait: timeout got cnt %0d want 5", m_cnt);
        end
        bus_if.enable = 1'b0;
        sb.delete();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_32f);
            checks++;
            if (sb.size() == 0) begin
                errors++; $display("FAIL stop_sb: scoreboard empty at %0d", i);
            end else begin
                exp = sb.pop_front();
                if (obs !== exp) begin
                    errors++; $display("FAIL stop cyc%0d: got %b want %b", i, obs, exp);
                end
            end
            if (!bus_if.running && idle_at < 0) idle_at = i;
        end
        checks++;
        if (idle_at !== 26) begin
            errors++; $display("FAIL stop_point: got %0d want 26", idle_at);
        end
        checks++;
        if (bus_if.clk_out !== '0 || bus_if.running !== 1'b0) begin
            errors++; $display("FAIL stop_final: got clk_out=%b running=%b want 0/0",
                               bus_if.clk_out, bus_if.running);
        end
        $display("test_stop done: idle_at=%0d", idle_at);
    endtask

    task automatic test_back_to_back();
        logic [EW-1:0] exp;
        int t;
        bit resumed = 1'b0, run_drop = 1'b0, relock = 1'b0;
        bus_if.enable = 1'b1;
        for (t = 0; t < 100 && !(m_locked && m_cnt == 9); t++) @(negedge clk_32f);
        checks++;
        if (!(m_locked && m_cnt == 9)) begin
            errors++; $display("FAIL b2b_wait: timeout got cnt %0d want 9", m_cnt);
        end
        bus_if.enable = 1'b0;
        sb.delete();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_32f);
            checks++;
            if (sb.size() == 0) begin
                errors++; $display("FAIL b2b_sb: scoreboard empty at %0d", i);
            end else begin
                exp = sb.pop_front();
                if (obs !== exp) begin
                    errors++; $display("FAIL b2b cyc%0d: got %b want %b", i, obs, exp);
                end
            end
            if (!bus_if.running) run_drop = 1'b1;
            if (resumed && bus_if.locked) relock = 1'b1;
            if (!resumed && m_cnt == 12) begin
                bus_if.enable = 1'b1;
                resumed = 1'b1;
            end
        end
        checks++;
        if (run_drop !== 1'b0 || relock !== 1'b1) begin
            errors++; $display("FAIL b2b_flags: got drop=%b relock=%b want 0/1",
                               run_drop, relock);
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_async_reset();
        logic [EW-1:0] exp;
        int t;
        for (t = 0; t < 100 && m_cnt != 13; t++) @(negedge clk_32f);
        checks++;
        if (bus_if.clk_out[0] !== 1'b1) begin
            errors++; $display("FAIL areset_pre: got clk_out0=%b want 1", bus_if.clk_out[0]);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (obs !== '0) begin
            errors++; $display("FAIL areset_async: got %b want %b", obs, {EW{1'b0}});
        end
        @(negedge clk_32f);
        reset = 1'b1;
        sb.delete();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_32f);
            checks++;
            if (sb.size() == 0) begin
                errors++; $display("FAIL areset_sb: scoreboard empty at %0d", i);
            end else begin
                exp = sb.pop_front();
                if (obs !== exp) begin
                    errors++; $display("FAIL areset cyc%0d: got %b want %b", i, obs, exp);
                end
            end
        end
        $display("test_async_reset done");
    endtask

`ifdef CLK_CHECK_EN
    task automatic test_checker();
        int t;
        for (t = 0; t < 100 && !m_locked; t++) @(negedge clk_32f);
        checks++;
        if (bus_if.mismatch !== '0 || bus_if.err_cnt !== 8'd0) begin
            errors++; $display("FAIL chk_pre: got %b/%0d want 000/0",
                               bus_if.mismatch, bus_if.err_cnt);
        end
        #1 inv_mask = 3'b010;
        repeat (3) @(negedge clk_32f);
        #1 inv_mask = '0;
        @(negedge clk_32f);
        checks++;
        if (bus_if.mismatch !== 3'b010 || bus_if.err_cnt !== 8'd3) begin
            errors++; $display("FAIL chk_count: got %b/%0d want 010/3",
                               bus_if.mismatch, bus_if.err_cnt);
        end
        bus_if.enable = 1'b0;
        for (t = 0; t < 100 && m_st != 0; t++) @(negedge clk_32f);
        checks++;
        if (bus_if.mismatch !== 3'b010 || bus_if.err_cnt !== 8'd3) begin
            errors++; $display("FAIL chk_sticky: got %b/%0d want 010/3",
                               bus_if.mismatch, bus_if.err_cnt);
        end
        bus_if.enable = 1'b1;
        @(negedge clk_32f);
        checks++;
        if (bus_if.mismatch !== '0 || bus_if.err_cnt !== 8'd0) begin
            errors++; $display("FAIL chk_clear: got %b/%0d want 000/0",
                               bus_if.mismatch, bus_if.err_cnt);
        end
        $display("test_checker done");
    endtask
`endif

    initial begin
        bus_if.enable = 1'b0;
        test_reset();
        test_run();
        test_stop();
        test_back_to_back();
        test_async_reset();
`ifdef CLK_CHECK_EN
        test_checker();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
